// File: rtl/pc_redirect_unit_if.sv
// PC-select bus between the PC forwarding logic (master) and the redirect unit (slave).
interface pc_redirect_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [2:0]       pc_mux_select;
  logic             stall;
  logic             freeze;
  logic [15:0]      rb_val;
  logic [15:0]      mem_val;
  logic [15:0]      pr2_target;
  logic [15:0]      pr3_target;
  logic [15:0]      lhi_val;
  logic [15:0]      alu_val;
  logic [15:0]      pc;
  logic [3:0]       flush;
  logic             redirect_taken;
  logic [CNT_W-1:0] redirect_count;
  logic             sel_error;

  modport master (
    output pc_mux_select, stall, freeze,
    output rb_val, mem_val, pr2_target, pr3_target, lhi_val, alu_val,
    input  pc, flush, redirect_taken, redirect_count, sel_error
  );

  modport slave (
    input  pc_mux_select, stall, freeze,
    input  rb_val, mem_val, pr2_target, pr3_target, lhi_val, alu_val,
    output pc, flush, redirect_taken, redirect_count, sel_error
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies forwarded redirect targets, issues flush pulses,
// and parks a redirect across pipeline freezes so it is applied exactly once.
module pc_redirect_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_redirect_unit_if.slave    bus
);

  localparam int unsigned PC_W = 16;
  localparam int unsigned FL_W = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [PC_W-1:0]   pend_target_q, pend_target_d;
  logic [FL_W-1:0]   pend_mask_q, pend_mask_d;

  logic [PC_W-1:0]   target_c;
  logic [FL_W-1:0]   mask_c;
  logic              redir_c;
  logic [PC_W-1:0]   pc_inc_c;

  // Select decode: redirect target and kill mask for the current select.
  always_comb begin
    target_c = pc_inc_c;
    mask_c   = '0;
    redir_c  = 1'b0;
    case (bus.pc_mux_select)
      3'd1: begin target_c = bus.rb_val;     mask_c = 4'b0011; redir_c = 1'b1; end
      3'd2: begin target_c = bus.mem_val;    mask_c = 4'b1111; redir_c = 1'b1; end
      3'd3: begin target_c = bus.pr2_target; mask_c = 4'b0001; redir_c = 1'b1; end
      3'd4: begin target_c = bus.pr3_target; mask_c = 4'b0011; redir_c = 1'b1; end
      3'd5: begin target_c = bus.lhi_val;    mask_c = 4'b0001; redir_c = 1'b1; end
      3'd6: begin target_c = bus.alu_val;    mask_c = 4'b0111; redir_c = 1'b1; end
      default: begin target_c = pc_inc_c; mask_c = '0; redir_c = 1'b0; end
    endcase
  end

  assign pc_inc_c = pc_q + PC_W'(1);

  // Next-state and registered-output logic for the RUN/HOLD controller.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = '0;
    taken_d       = 1'b0;
    count_d       = count_q;
    err_d         = err_q;
    pend_target_d = pend_target_q;
    pend_mask_d   = pend_mask_q;

    case (state_q)
      RUN: begin
        if (bus.pc_mux_select == 3'd7) begin
          err_d = 1'b1;
        end
        if (bus.freeze) begin
          if (redir_c) begin
            pend_target_d = target_c;
            pend_mask_d   = mask_c;
            state_d       = HOLD;
          end
        end else if (redir_c) begin
          pc_d    = target_c;
          flush_d = mask_c;
          taken_d = 1'b1;
          count_d = count_q + CNT_W'(1);
        end else if (!bus.stall) begin
          pc_d = pc_inc_c;
        end
      end
      HOLD: begin
        // Select is frozen and stale here; only the parked redirect matters.
        if (!bus.freeze) begin
          pc_d    = pend_target_q;
          flush_d = pend_mask_q;
          taken_d = 1'b1;
          count_d = count_q + CNT_W'(1);
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers; reset discards any parked redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      flush_q       <= '0;
      taken_q       <= 1'b0;
      count_q       <= '0;
      err_q         <= 1'b0;
      pend_target_q <= '0;
      pend_mask_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      taken_q       <= taken_d;
      count_q       <= count_d;
      err_q         <= err_d;
      pend_target_q <= pend_target_d;
      pend_mask_q   <= pend_mask_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_taken = taken_q;
  assign bus.redirect_count = count_q;
  assign bus.sel_error      = err_q;

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the 3-bit PC-select interface produced by the pipeline's PC forwarding logic.
- Owns the architectural fetch PC register and applies the selected redirect target.
- Issues flush pulses to the pipeline registers younger than the redirecting instruction.
- Holds a pending redirect across whole-pipeline freezes so each redirect is applied and counted exactly once.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
CNT_W, 16, width of redirect performance counter

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous active-high reset
pc_mux_select  in  3  select from PC forwarding (changes on negedge, sampled on posedge)
stall  in  1  front-end stall (hold PC, pr1, pr2)
freeze  in  1  whole-pipeline freeze (memory busy); nothing advances
rb_val  in  16  RFout2 of pr3 (JLR target)
mem_val  in  16  load data of pr5 (LW/LM to R7)
pr2_target  in  16  PC+Imm of pr2 (JAL)
pr3_target  in  16  PC+Imm6 of pr3 (BEQ taken)
lhi_val  in  16  {Imm9,7'b0} from pr2 (LHI to R7)
alu_val  in  16  ALU result in pr4 (ALU op writing R7)
pc  out  16  current fetch PC
flush  out  4  one-cycle kill pulses; bit i kills pr(i+1)
redirect_taken  out  1  one-cycle pulse when a redirect is applied
redirect_count  out  CNT_W  number of applied redirects, wraps
sel_error  out  1  sticky, set on select value 7

Behaviour:
- Reset (async, immediate): pc=RESET_PC, flush=0, redirect_taken=0, redirect_count=0, sel_error=0, state=RUN, pending target/depth=0.
- Select decode:
  - 0: no redirect, target pc+1.
  - 1: target rb_val, flush 4'b0011.
  - 2: target mem_val, flush 4'b1111.
  - 3: target pr2_target, flush 4'b0001.
  - 4: target pr3_target, flush 4'b0011.
  - 5: target lhi_val, flush 4'b0001.
  - 6: target alu_val, flush 4'b0111.
  - 7: illegal; treated as 0, sets sel_error (cleared only by reset).
- pc+1 wraps 16'hFFFF -> 16'h0000; redirect_count wraps at 2^CNT_W.
- State RUN, each posedge:
  - freeze=1, sel in 1..6: latch target and flush mask into pending; go to HOLD. pc unchanged, flush=0, no count.
  - freeze=1, sel=0: hold everything.
  - freeze=0, sel in 1..6: pc<=target; flush<=mask; redirect_taken<=1; count++. Applied even if stall=1 (redirect overrides stall).
  - freeze=0, sel=0, stall=1: pc held.
  - freeze=0, sel=0, stall=0: pc<=pc+1.
- State HOLD:
  - freeze=1: hold; ignore pc_mux_select (IRs are frozen, so the repeated select must not re-latch). First latched redirect wins.
  - freeze=0: pc<=pending target; flush<=pending mask; redirect_taken<=1; count++; go to RUN. pc_mux_select is ignored this cycle.
- flush and redirect_taken are registered, asserted exactly one cycle, and aligned with the pc update edge.
- Latency: select sampled at posedge N gives the new pc and flush visible after posedge N. The cycle after a redirect is a normal RUN evaluation using the refreshed select.
- Reset asserted mid-HOLD discards the pending redirect.

Test Plan:
- Reset then 3 idle cycles, sel=0, stall=0 -> pc 0000, 0001, 0002, 0003; flush=0; count=0.
- pc=0010, sel=4, pr3_target=0040 -> next pc=0040; flush=0011; redirect_taken=1 for one cycle; count=1; following cycle pc=0041.
- stall=1, sel=2, mem_val=1234 -> pc=1234, flush=1111 (stall overridden); with stall=1 and sel=0 the next cycle, pc holds at 1234.
- freeze=1 for 3 cycles with sel=6 steady, alu_val=0BEE, then freeze=0 -> pc unchanged during freeze, then pc=0BEE, flush=0111, count incremented by exactly 1.
- pc=FFFF, sel=0 -> pc=0000. Separately, sel=7 -> treated as pc+1, sel_error=1 and stays set.
- In HOLD with pending target 0500, assert reset -> pc=RESET_PC, state RUN; after reset release with freeze=0, no redirect applied and count=0.
